// File: rtl/fifo_burst_reader_if.sv
// Bundle for the FIFO read port and the downstream valid/ready stream.
// master: burst reader side. slave: FIFO plus consumer side.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 33
);
  logic                   fifo_rd_en;
  logic [DATA_WIDTH-1:0]  fifo_data_out;
  logic                   fifo_empty;
  logic [COUNT_WIDTH-1:0] fifo_count;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_last;
  logic                   m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_data_out,
    input  fifo_empty,
    input  fifo_count,
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_data_out,
    output fifo_empty,
    output fifo_count,
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO into a framed valid/ready burst stream.
// Optional idle auto-flush: define FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 33,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  fifo_burst_reader_if.master bus,
  output logic        busy,
  output logic        burst_done,
  output logic [31:0] words_sent
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] BL =
    COUNT_WIDTH'(BURST_LEN);
  localparam logic [COUNT_WIDTH-1:0] ONE =
    COUNT_WIDTH'(1);

  if (BURST_LEN < 1) begin : g_bad_len
    $error("BURST_LEN must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_tmo
    $error("TIMEOUT must be at least 1");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [COUNT_WIDTH-1:0] len_nxt;
  logic                   load;
  logic                   inflight;
  logic                   inflight_last;
  logic [1:0]             occ;
  logic [DATA_WIDTH-1:0]  d0;
  logic [DATA_WIDTH-1:0]  d1;
  logic                   l0;
  logic                   l1;
  logic                   valid;
  logic                   pop;
  logic                   push;
  logic                   rd_en;
  logic                   flush_eff;
  logic [2:0]             fill;

`ifdef FIFO_RD_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Count idle cycles spent holding a partial burst
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state == IDLE &&
                 bus.fifo_count != '0 &&
                 bus.fifo_count < BL) begin
      idle_cnt <= idle_cnt + 32'd1;
    end else begin
      idle_cnt <= '0;
    end
  end

  assign flush_eff = flush ||
    (idle_cnt == 32'(TIMEOUT));
`else
  assign flush_eff = flush;
`endif

  assign valid = (occ != 2'd0);
  assign pop   = valid && bus.m_ready;
  assign push  = inflight;
  assign fill  = {1'b0, occ} + {2'b0, inflight}
               - {2'b0, pop};

  assign rd_en = (state == READ) &&
                 (remaining != '0) &&
                 !bus.fifo_empty &&
                 (fill < 3'd2);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = d0;
  assign bus.m_last     = l0 && valid;
  assign busy           = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and burst length selection
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    len_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (bus.fifo_count >= BL) begin
          load      = 1'b1;
          len_nxt   = BL;
          state_nxt = READ;
        end else if (flush_eff &&
                     bus.fifo_count != '0) begin
          load      = 1'b1;
          len_nxt   = bus.fifo_count;
          state_nxt = READ;
        end
      end
      READ: begin
        if (rd_en && remaining == ONE) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && l0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reads still owed for this burst
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= len_nxt;
    end else if (rd_en) begin
      remaining <= remaining - ONE;
    end
  end

  // Track the read whose data returns next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && (remaining == ONE);
    end
  end

  // Two-entry output buffer, head in d0/l0
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            d0 <= bus.fifo_data_out;
            l0 <= inflight_last;
          end else begin
            d1 <= bus.fifo_data_out;
            l1 <= inflight_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            d0 <= d1;
            l0 <= l1;
            d1 <= bus.fifo_data_out;
            l1 <= inflight_last;
          end else begin
            d0 <= bus.fifo_data_out;
            l0 <= inflight_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Transfer count and end-of-burst pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      words_sent <= '0;
      burst_done <= 1'b0;
    end else begin
      if (pop) begin
        words_sent <= words_sent + 32'd1;
      end
      burst_done <= (state == DRAIN) && pop && l0;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a behavioural FIFO.
// Covers full/partial bursts, backpressure, reset abort, timeout.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        busy;
  logic        burst_done;
  logic [31:0] words_sent;
  logic        fifo_clr;

  fifo_burst_reader_if #(
    .DATA_WIDTH(8),
    .COUNT_WIDTH(33)
  ) bus ();

  fifo_burst_reader #(
    .DATA_WIDTH(8),
    .COUNT_WIDTH(33),
    .BURST_LEN(8),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .busy(busy),
    .burst_done(burst_done),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_data_out <= mem[8'(rd_ptr)];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always_comb begin
    bus.fifo_count = 33'(wr_ptr - rd_ptr);
    bus.fifo_empty = (wr_ptr == rd_ptr);
  end

  int vec = 0;
  int fails = 0;
  int bd_cnt = 0;
  logic [8:0] exp_q [$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    vec++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[8'(wr_ptr + i)] = 8'(base + i);
    end
    wr_ptr = wr_ptr + n;
  endtask

  task automatic expect_words(input int base,
                              input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({((i + 1) % 8 == 0) ||
                       (i == n - 1),
                       8'(base + i)});
    end
  endtask

  task automatic wait_drained(input string name,
                              input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) &&
           k < bound) begin
      step;
      k++;
    end
    check(name, {exp_q.size() != 0, busy}, 0);
  endtask

  // Monitor: scoreboard pops, stall stability, read safety
  initial begin
    logic       stall_prev;
    logic [8:0] prev;
    logic [8:0] e;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.fifo_rd_en)
          check("rd_en_while_empty",
                64'(bus.fifo_empty), 0);
        if (stall_prev)
          check("stall_hold",
                {bus.m_valid, bus.m_last, bus.m_data},
                {1'b1, prev});
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            vec++;
            fails++;
            $display("FAIL unexpected_word: got %0h want none",
                     {bus.m_last, bus.m_data});
          end else begin
            e = exp_q.pop_front();
            check("word",
                  {bus.m_last, bus.m_data}, e);
          end
        end
        if (burst_done) bd_cnt++;
      end
      stall_prev = !rst && bus.m_valid && !bus.m_ready;
      prev = {bus.m_last, bus.m_data};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int k;
    int t0;
    int t1;
    int bd0;
    logic [4:0] pat;
    rst = 1'b1;
    flush = 1'b0;
    fifo_clr = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) step;
    check("rst_m_valid", 64'(bus.m_valid), 0);
    check("rst_m_last", 64'(bus.m_last), 0);
    check("rst_m_data", 64'(bus.m_data), 0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_burst_done", 64'(burst_done), 0);
    check("rst_words_sent", 64'(words_sent), 0);
    rst = 1'b0;
    step;

    // one full burst, back-to-back
    bus.m_ready = 1'b1;
    load(8'h10, 8);
    expect_words(8'h10, 8);
    k = 0;
    while (!bus.m_valid && k < 20) begin
      step;
      k++;
    end
    check("b1_first_valid", 64'(bus.m_valid), 1);
    t0 = cyc;
    while (!burst_done && k < 60) begin
      step;
      k++;
    end
    check("b1_done_seen", 64'(burst_done), 1);
    t1 = cyc;
    check("b1_span", 64'(t1 - t0), 8);
    step;
    check("b1_done_pulse", 64'(burst_done), 0);
    wait_drained("b1_drain", 20);
    check("b1_words_sent", 64'(words_sent), 8);
    check("b1_bursts", 64'(bd_cnt), 1);

    // two full bursts then flushed remainder
    load(8'h00, 20);
    expect_words(8'h00, 20);
    k = 0;
    while ((exp_q.size() != 4 || busy) && k < 100) begin
      step;
      k++;
    end
    repeat (4) step;
    check("b2_left_count", 64'(bus.fifo_count), 4);
    check("b2_idle", 64'(busy), 0);
    check("b2_bursts", 64'(bd_cnt), 3);
    flush = 1'b1;
    step;
    flush = 1'b0;
    wait_drained("b2_flush_drain", 60);
    step;
    check("b2_flush_bursts", 64'(bd_cnt), 4);
    check("b2_words_sent", 64'(words_sent), 28);

    // backpressure 1,0,0,1,0 repeating
    pat = 5'b01001;
    load(8'h20, 8);
    expect_words(8'h20, 8);
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 120) begin
      bus.m_ready = pat[k % 5];
      step;
      k++;
    end
    check("bp_drain", {exp_q.size() != 0, busy}, 0);
    bus.m_ready = 1'b1;
    step;
    step;
    check("bp_bursts", 64'(bd_cnt), 5);
    check("bp_words_sent", 64'(words_sent), 36);

    // flush with an empty FIFO is ignored
    flush = 1'b1;
    step;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fe_busy", 64'(busy), 0);
      check("fe_rd_en", 64'(bus.fifo_rd_en), 0);
      step;
    end

    // reset three cycles into a stalled burst
    bus.m_ready = 1'b0;
    load(8'h40, 8);
    k = 0;
    while (!busy && k < 10) begin
      step;
      k++;
    end
    check("ra_started", 64'(busy), 1);
    repeat (3) step;
    bd0 = bd_cnt;
    rst = 1'b1;
    fifo_clr = 1'b1;
    step;
    rst = 1'b0;
    fifo_clr = 1'b0;
    check("ra_m_valid", 64'(bus.m_valid), 0);
    check("ra_m_last", 64'(bus.m_last), 0);
    check("ra_m_data", 64'(bus.m_data), 0);
    check("ra_rd_en", 64'(bus.fifo_rd_en), 0);
    check("ra_busy", 64'(busy), 0);
    check("ra_burst_done", 64'(burst_done), 0);
    check("ra_words_sent", 64'(words_sent), 0);
    bus.m_ready = 1'b1;
    repeat (10) step;
    check("ra_no_done", 64'(bd_cnt), 64'(bd0));
    check("ra_no_words", 64'(words_sent), 0);

    // partial burst without flush
    load(8'h30, 3);
    t0 = cyc;
`ifdef FIFO_RD_TIMEOUT_EN
    expect_words(8'h30, 3);
    k = 0;
    while (!bus.fifo_rd_en && k < 40) begin
      step;
      k++;
    end
    check("to_rd_seen", 64'(bus.fifo_rd_en), 1);
    check("to_start", 64'(cyc - t0), 17);
    wait_drained("to_drain", 30);
    step;
    check("to_bursts", 64'(bd_cnt), 64'(bd0 + 1));
    check("to_words_sent", 64'(words_sent), 3);
`else
    repeat (40) step;
    check("nto_idle", 64'(busy), 0);
    check("nto_count", 64'(bus.fifo_count), 3);
    check("nto_words_sent", 64'(words_sent), 0);
`endif

    step;
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, fails);
    $finish;
  end

endmodule
